dcache: RTL and testbench

Direct-mapped, write-back data cache placed between the CPU datapath and the 32-bit-block data memory. It serves byte loads and stores from the ALU-computed address. Load data feeds the register file write-data mux (`reg_file.IN`). `BUSYWAIT` stalls the PC and the register-file write until each access completes.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_line_array.sv | 55 +++++
 rtl/dcache.sv | 108 ++++++++++
 tb/tb_dcache.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field geometry for the direct-mapped byte data cache.
// Field layout of the 8-bit byte address: {tag[7:5], index[4:2], offset[1:0]}.
package dcache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;
  localparam int LINES    = 1 << INDEX_W;

  localparam int OFF_LSB  = 0;
  localparam int IDX_LSB  = OFFSET_W;
  localparam int TAG_LSB  = OFFSET_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data with a combinational read port, a byte-write port
// and a full-line fill port; RESET clears only the valid and dirty bits.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [7:0]          wr_byte,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
      dirty[fill_index] <= 1'b0;
    end else if (wr_en) begin
      dirty[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left unreset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_mem[fill_index] <= fill_data;
      tag_mem[fill_index]  <= fill_tag;
    end else if (wr_en) begin
      data_mem[wr_index][{wr_offset, 3'b000} +: 8] <= wr_byte;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back byte cache: hits complete in the request cycle with no stall,
// misses hold BUSYWAIT through optional victim write-back and block fetch.
module dcache
  import dcache_pkg::state_t, dcache_pkg::IDLE, dcache_pkg::WRITEBACK, dcache_pkg::FETCH,
         dcache_pkg::TAG_LSB, dcache_pkg::IDX_LSB, dcache_pkg::OFF_LSB;
#(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              READ,
  input  logic                              WRITE,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] ADDRESS,
  input  logic [7:0]                        WRITEDATA,
  output logic [7:0]                        READDATA,
  output logic                              BUSYWAIT,
  output logic                              MEM_READ,
  output logic                              MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0]          MEM_ADDRESS,
  output logic [31:0]                       MEM_WRITEDATA,
  input  logic [31:0]                       MEM_READDATA,
  input  logic                              MEM_BUSYWAIT
);

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_off;
  logic                rd_valid, rd_dirty, hit, req, wr_en, fill_en;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_data;
  logic [7:0]          sel_byte;
  state_t              state, state_nxt;

  assign addr_tag   = ADDRESS[TAG_LSB +: TAG_W];
  assign addr_index = ADDRESS[IDX_LSB +: INDEX_W];
  assign addr_off   = ADDRESS[OFF_LSB +: OFFSET_W];
  assign req        = READ | WRITE;
  assign hit        = rd_valid && (rd_tag == addr_tag);
  assign sel_byte   = rd_data[{addr_off, 3'b000} +: 8];

  dcache_line_array u_lines (
    .CLK        (CLK),
    .RESET      (RESET),
    .rd_index   (addr_index),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_index   (addr_index),
    .wr_offset  (addr_off),
    .wr_byte    (WRITEDATA),
    .fill_en    (fill_en),
    .fill_index (addr_index),
    .fill_tag   (addr_tag),
    .fill_data  (MEM_READDATA)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req && !hit) state_nxt = (rd_valid && rd_dirty) ? WRITEBACK : FETCH;
      WRITEBACK: if (!MEM_BUSYWAIT) state_nxt = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A simultaneous READ and WRITE is a store, so it never drives READDATA.
  always_comb begin
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = 8'h00;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = req && !hit;
        if (hit && WRITE)     wr_en    = !RESET;
        else if (hit && READ) READDATA = sel_byte;
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {rd_tag, addr_index};
        MEM_WRITEDATA = rd_data;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_index};
        fill_en     = !MEM_BUSYWAIT && !RESET;
      end
      default: BUSYWAIT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a latency-programmable block memory model.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  int total = 0;
  int bad   = 0;
  int lat_r = 1;
  int lat_w = 1;
  int cnt   = 0;
  int n_busy, n_rd, n_wr;
  logic [5:0]  wb_addr, fetch_addr;
  logic [31:0] wb_data;
  logic        mem_init = 1'b1;
  logic [31:0] mem [64];

  always #5 CLK = ~CLK;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Memory completes on the lat-th consecutive cycle a strobe is held.
  assign MEM_BUSYWAIT = !((MEM_READ && cnt == lat_r - 1) || (MEM_WRITE && cnt == lat_w - 1));
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[6'h09] <= 32'hDDCCBBAA;
      mem[6'h29] <= 32'h44332211;
      mem[6'h39] <= 32'h00000077;
      cnt <= 0;
    end else begin
      if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) cnt <= cnt + 1;
      else                                         cnt <= 0;
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  // Steps a stalled access mid-cycle until BUSYWAIT drops; returns in the completing cycle.
  task automatic run_access();
    logic done;
    done   = 1'b0;
    n_busy = 0;
    n_rd   = 0;
    n_wr   = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      #4;
      if (!BUSYWAIT) begin
        done = 1'b1;
      end else begin
        n_busy++;
        if (MEM_READ)  begin n_rd++; fetch_addr = MEM_ADDRESS; end
        if (MEM_WRITE) begin n_wr++; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
        adv();
      end
    end
    chk("access_completes", {31'b0, done}, 32'h1);
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    mem_init = 1'b0;
    #4;
    chk("rst_mem_read",  {31'b0, MEM_READ},  32'h0);
    chk("rst_mem_write", {31'b0, MEM_WRITE}, 32'h0);
    chk("rst_mem_addr",  {26'b0, MEM_ADDRESS}, 32'h0);
    chk("rst_readdata",  {24'b0, READDATA},  32'h0);
    chk("rst_busy_idle", {31'b0, BUSYWAIT},  32'h0);
    READ = 1'b1; ADDRESS = 8'h24;
    #1;
    chk("rst_busy_req",  {31'b0, BUSYWAIT},  32'h1);
    adv();
    RESET = 1'b0;

    // Clean miss, latency 5.
    lat_r = 5;
    run_access();
    chk("miss1_busy",    n_busy, 6);
    chk("miss1_rd",      n_rd, 5);
    chk("miss1_wr",      n_wr, 0);
    chk("miss1_faddr",   {26'b0, fetch_addr}, 32'h09);
    chk("miss1_data",    {24'b0, READDATA}, 32'hAA);
    adv();

    ADDRESS = 8'h27;
    #4;
    chk("hit27_busy",    {31'b0, BUSYWAIT}, 32'h0);
    chk("hit27_data",    {24'b0, READDATA}, 32'hDD);
    chk("hit27_memrd",   {31'b0, MEM_READ}, 32'h0);
    adv();

    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h25; WRITEDATA = 8'h5A;
    #4;
    chk("whit_busy",     {31'b0, BUSYWAIT}, 32'h0);
    chk("whit_rdata",    {24'b0, READDATA}, 32'h0);
    adv();
    READ = 1'b1; WRITE = 1'b0;
    #4;
    chk("rb25_busy",     {31'b0, BUSYWAIT}, 32'h0);
    chk("rb25_data",     {24'b0, READDATA}, 32'h5A);
    adv();

    // Dirty victim: write-back then fetch.
    ADDRESS = 8'hA4; lat_w = 3; lat_r = 2;
    run_access();
    chk("dmiss_busy",    n_busy, 6);
    chk("dmiss_wr",      n_wr, 3);
    chk("dmiss_rd",      n_rd, 2);
    chk("dmiss_waddr",   {26'b0, wb_addr}, 32'h09);
    chk("dmiss_wdata",   wb_data, 32'hDDCC5AAA);
    chk("dmiss_faddr",   {26'b0, fetch_addr}, 32'h29);
    chk("dmiss_data",    {24'b0, READDATA}, 32'h11);
    adv();
    chk("mem9_written",  mem[6'h09], 32'hDDCC5AAA);

    // Reset in the middle of a fetch.
    ADDRESS = 8'h24; lat_r = 10;
    #4;
    chk("rf_req_busy",   {31'b0, BUSYWAIT}, 32'h1);
    chk("rf_req_memrd",  {31'b0, MEM_READ}, 32'h0);
    adv();
    #4;
    chk("rf_fetch_rd",   {31'b0, MEM_READ}, 32'h1);
    chk("rf_fetch_addr", {26'b0, MEM_ADDRESS}, 32'h09);
    adv();
    RESET = 1'b1;
    adv();
    #4;
    chk("rf_drop_rd",    {31'b0, MEM_READ}, 32'h0);
    chk("rf_drop_addr",  {26'b0, MEM_ADDRESS}, 32'h0);
    chk("rf_busy",       {31'b0, BUSYWAIT}, 32'h1);
    chk("rf_rdata",      {24'b0, READDATA}, 32'h0);
    adv();
    RESET = 1'b0; lat_r = 2;
    run_access();
    chk("rf_miss_busy",  n_busy, 3);
    chk("rf_miss_rd",    n_rd, 2);
    chk("rf_miss_wr",    n_wr, 0);
    chk("rf_miss_data",  {24'b0, READDATA}, 32'hAA);
    adv();
    ADDRESS = 8'h25;
    #4;
    chk("rf_hit25",      {24'b0, READDATA}, 32'h5A);
    adv();

    // READ and WRITE together act as a store.
    WRITE = 1'b1; ADDRESS = 8'h26; WRITEDATA = 8'hC3;
    #4;
    chk("rw_busy",       {31'b0, BUSYWAIT}, 32'h0);
    chk("rw_rdata",      {24'b0, READDATA}, 32'h0);
    adv();
    WRITE = 1'b0;
    #4;
    chk("rw_readback",   {24'b0, READDATA}, 32'hC3);
    adv();
    ADDRESS = 8'hE4; lat_w = 1; lat_r = 1;
    run_access();
    chk("rw_ev_busy",    n_busy, 3);
    chk("rw_ev_wr",      n_wr, 1);
    chk("rw_ev_waddr",   {26'b0, wb_addr}, 32'h09);
    chk("rw_ev_wdata",   wb_data, 32'hDDC35AAA);
    chk("rw_ev_faddr",   {26'b0, fetch_addr}, 32'h39);
    chk("rw_ev_data",    {24'b0, READDATA}, 32'h77);
    adv();

    READ = 1'b0;
    #4;
    chk("idle_busy",     {31'b0, BUSYWAIT}, 32'h0);
    chk("idle_strobes",  {30'b0, MEM_READ, MEM_WRITE}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
